// File: rtl/reg_arb.sv
// reg_arb: two-requester arbiter in front of a single-port register file.
// m0 (SPI instruction decoder) and m1 (internal update engine) each own one
// pending slot. An IDLE/ACCESS FSM grants one slot at a time, so a grant can
// start at most every second cycle.
// Optional feature macro: REG_ARB_FIXED_PRIO_EN. When it is defined, m0 always
// wins a tie. When it is undefined, ties are broken round-robin.
//
// Handshake: mX_read/mX_write are single-cycle pulses with no backpressure.
// A request into a free slot is always accepted. A request into a busy slot is
// dropped (mX_drop pulses next cycle), unless that slot is completing in this
// ACCESS cycle. read/write are single-cycle strobes, and data_read is sampled
// in the strobe cycle. mX_ack pulses the cycle after the strobe.
module reg_arb #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_ack,
  output logic              m0_drop,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_ack,
  output logic              m1_drop,
  output logic              read,
  output logic              write,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data_write,
  input  logic [DATA_W-1:0] data_read,
  output logic              busy,
  output logic              dbg_state
);

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  state_t r_state;
  state_t w_next;

  // Pending slots, indexed by requester
  logic [1:0]        r_pend;
  logic [1:0]        r_rw;      // 1 = write
  logic [ADDR_W-1:0] r_saddr  [2];
  logic [DATA_W-1:0] r_swdata [2];

  // Grant bookkeeping and register-file side
  logic              r_grant;   // requester owning the current access
  logic              r_last;    // requester granted most recently
  logic              r_read;
  logic              r_write;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata0;
  logic [DATA_W-1:0] r_rdata1;
  logic [1:0]        r_ack;
  logic [1:0]        r_drop;

  logic              w_start;
  logic              w_done;
  logic              w_sel;
  logic [1:0]        w_req;
  logic [1:0]        w_req_wr;
  logic [ADDR_W-1:0] w_req_addr  [2];
  logic [DATA_W-1:0] w_req_wdata [2];
  logic [1:0]        w_done_vec;
  logic [1:0]        w_accept;
  logic [1:0]        w_drop;

  // Gather the two request ports into vectors so the slot logic is uniform
  always_comb begin
    w_req          = {m1_read | m1_write, m0_read | m0_write};
    w_req_wr       = {m1_write, m0_write};
    w_req_addr[0]  = m0_addr;
    w_req_addr[1]  = m1_addr;
    w_req_wdata[0] = m0_wdata;
    w_req_wdata[1] = m1_wdata;
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Next state, grant start/finish and winner selection
  always_comb begin
    w_next  = r_state;
    w_start = 1'b0;
    w_done  = 1'b0;
    w_sel   = 1'b0;
`ifdef REG_ARB_FIXED_PRIO_EN
    w_sel = r_pend[0] ? 1'b0 : 1'b1;
`else
    if (r_pend[0] && r_pend[1]) w_sel = ~r_last;
    else                        w_sel = r_pend[0] ? 1'b0 : 1'b1;
`endif
    case (r_state)
      IDLE: begin
        if (|r_pend) begin
          w_next  = ACCESS;
          w_start = 1'b1;
        end
      end
      ACCESS: begin
        w_next = IDLE;
        w_done = 1'b1;
      end
      default: w_next = IDLE;
    endcase
  end

  // A slot finishing in this ACCESS cycle may be reloaded by a new request
  always_comb begin
    w_done_vec = {w_done & r_grant, w_done & ~r_grant};
    w_accept   = w_req & (~r_pend | w_done_vec);
    w_drop     = w_req & ~w_accept;
  end

  // Pending slot load / clear; write wins when both strobes arrive together
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend <= '0;
      r_rw   <= '0;
      for (int i = 0; i < 2; i++) begin
        r_saddr[i]  <= '0;
        r_swdata[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (w_accept[i]) begin
          r_pend[i]   <= 1'b1;
          r_rw[i]     <= w_req_wr[i];
          r_saddr[i]  <= w_req_addr[i];
          r_swdata[i] <= w_req_wdata[i];
        end else if (w_done_vec[i]) begin
          r_pend[i] <= 1'b0;
        end
      end
    end
  end

  // Grant launch, strobe generation, read capture and ack/drop pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_grant  <= 1'b0;
      r_last   <= 1'b1;
      r_read   <= 1'b0;
      r_write  <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata0 <= '0;
      r_rdata1 <= '0;
      r_ack    <= '0;
      r_drop   <= '0;
    end else begin
      r_ack  <= w_done_vec;
      r_drop <= w_drop;
      if (w_start) begin
        r_grant <= w_sel;
        r_last  <= w_sel;
        r_addr  <= r_saddr[w_sel];
        r_wdata <= r_swdata[w_sel];
        r_read  <= ~r_rw[w_sel];
        r_write <= r_rw[w_sel];
      end else if (w_done) begin
        r_read  <= 1'b0;
        r_write <= 1'b0;
        if (r_read) begin
          if (r_grant) r_rdata1 <= data_read;
          else         r_rdata0 <= data_read;
        end
      end
    end
  end

  assign read       = r_read;
  assign write      = r_write;
  assign addr       = r_addr;
  assign data_write = r_wdata;
  assign m0_rdata   = r_rdata0;
  assign m1_rdata   = r_rdata1;
  assign m0_ack     = r_ack[0];
  assign m1_ack     = r_ack[1];
  assign m0_drop    = r_drop[0];
  assign m1_drop    = r_drop[1];
  assign busy       = (r_state != IDLE) | (|r_pend);
  assign dbg_state  = r_state;

endmodule

// File: doc/reg_arb.md
REG_ARB -- requirements
Module: reg_arb

Interface
REQ-001 Parameter ADDR_W, default 6, register address width.
REQ-002 Parameter DATA_W, default 8, register data width.
REQ-003 clk  input  1  single block clock; all logic on rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 mX_read / mX_write (X=0,1)  input  1 each  one-cycle request pulses from requester X; m0 is the SPI instruction decoder, m1 is the internal update engine.
REQ-006 mX_addr  input  ADDR_W  request address; sampled with the request pulse.
REQ-007 mX_wdata  input  DATA_W  write data; sampled with the request pulse.
REQ-008 mX_rdata  output  DATA_W  last read result returned to requester X.
REQ-009 mX_ack  output  1  one-cycle pulse when requester X's access completes.
REQ-010 mX_drop  output  1  one-cycle pulse when a request from X is discarded.
REQ-011 read / write  output  1 each  register-file access strobes.
REQ-012 addr / data_write  output  ADDR_W / DATA_W  register-file address and write data.
REQ-013 data_read  input  DATA_W  register-file read data, valid in the cycle read is high.
REQ-014 busy  output  1  high while state is not IDLE or any pending slot is set.

Function
REQ-015 Per requester, one pending slot (pend, rw, addr, wdata); a request pulse seen in cycle N sets the slot at the end of N; mX_write takes precedence if both strobes are high.
REQ-016 FSM states: IDLE, ACCESS; IDLE -> ACCESS when a slot is pending; ACCESS -> IDLE unconditionally after one cycle.
REQ-017 On the IDLE->ACCESS edge: select the winner, register its addr and wdata, and assert exactly one of read/write for the ACCESS cycle only.
REQ-018 On the ACCESS->IDLE edge: for a read, capture data_read into mX_rdata; clear the winner's slot; pulse mX_ack in the following cycle.
REQ-019 Latency: request in cycle N -> strobe in N+2 -> ack in N+3; back-to-back grants every 2 cycles.
REQ-020 Arbitration is round-robin: when both slots are pending, the requester not granted last wins; after reset, m0 has priority.
REQ-021 A request arriving while its own slot is pending is discarded and mX_drop pulses next cycle; exception: a request arriving in the ACCESS cycle that completes that slot is accepted and reloads the slot.
REQ-022 Writes leave mX_rdata unchanged; mX_rdata holds until the next read ack for X.
REQ-023 Simultaneous requests from m0 and m1 in the same cycle are both accepted into their slots.
REQ-024 read and write are never high together; neither is high outside ACCESS.

Reset
REQ-025 rst_n low asynchronously forces: state IDLE; all slots clear; read, write, mX_ack, mX_drop, busy = 0; addr = 0; data_write = 0; mX_rdata = 0; last-grant = m1.
REQ-026 Reset during ACCESS aborts the access with no ack; no strobe or pulse is emitted in the first cycle after release.

Configuration
REQ-027 Macro REG_ARB_FIXED_PRIO_EN: when defined, m0 always wins when both slots are pending (fixed priority); when undefined, round-robin per REQ-020.

Verification
REQ-028 m0_read pulse, addr 0x03, data_read = 0xA5 -> read high in cycle N+2 with addr = 0x03; m0_ack in N+3; m0_rdata = 0xA5.
REQ-029 m1_write addr 0x08, wdata 0x3C -> write high exactly 1 cycle with data_write = 0x3C; m1_ack in N+3; m1_rdata unchanged.
REQ-030 m0 and m1 reads in the same cycle, repeated 4 times -> grants alternate m0, m1, m0, m1 (macro undefined); with the macro defined, each m0 access is granted before the pending m1 access.
REQ-031 Second m0_read 1 cycle after the first -> m0_drop pulse; only one access occurs. A re-request in the ACCESS cycle is accepted, and a second ack arrives 2 cycles later.
REQ-032 rst_n asserted in the ACCESS cycle -> all outputs 0 immediately; no ack; busy = 0 after release.
